core_exec_ctrl: RTL and testbench
=================================

// Module: core_exec_ctrl
// PURPOSE
//  Parametrised core execution controller for multi-core test harnesses. Drives per-core clock
//  enables and resets under command control: power-on reset sequence, N-tick pulse, free run, stop.
//  Shared programmable divider sets tick rate. Sits between command interpreter and 1..NUM_CORES cores.
// PARAMETERS
//  NUM_CORES           1   number of independent core channels (1..16)
//  PULSE_CONTROL_BITS  12  width of pulse count N (cmd_arg[PULSE_CONTROL_BITS-1:0])
//  DIV_BITS            16  width of tick divider value (cmd_arg[DIV_BITS-1:0])
//  RESET_CLK_CYCLES    20  core_reset assertion length in clk cycles (>=1)
// PORTS
//  clk            in   1          system clock; all logic on rising edge
//  reset          in   1          asynchronous, active-low reset
//  cmd_valid      in   1          command present
//  cmd_ready      out  1          command accepted when cmd_valid & cmd_ready
//  cmd_op         in   3          opcode: 0 NOP,1 RESET_CORE,2 PULSE,3 RUN,4 STOP,5 SET_DIV, 6-7 NOP
//  cmd_core_sel   in   NUM_CORES  one-hot/multi-hot channel mask (ignored by SET_DIV)
//  cmd_arg        in   32         operand (N for PULSE, divider for SET_DIV)
//  core_clk_en    out  NUM_CORES  per-core clock enable, one clk wide per tick
//  core_reset     out  NUM_CORES  per-core active-high reset
//  busy           out  NUM_CORES  channel state != IDLE
//  done           out  NUM_CORES  1-cycle pulse on PULSE/RESET_CORE completion
// BEHAVIOUR
//  - reset low: all channels forced to RESET, rst_cnt=0, div_value=0, div_cnt=0, core_reset=all 1,
//    core_clk_en=0, done=0, busy=all 1, cmd_ready=0. After release: power-on RESET sequence runs.
//  - Divider: tick = (div_cnt==div_value); div_cnt wraps to 0 on tick else +1. div_value=0 -> tick every clk.
//  - SET_DIV: div_value<=cmd_arg[DIV_BITS-1:0], div_cnt<=0 next edge; channel states/counts untouched.
//  - Channel FSM (per core): IDLE, RESET, PULSE, RUN.
//    RESET: core_reset=1 for exactly RESET_CLK_CYCLES clk cycles, then IDLE, done pulse on the cycle
//    after the last reset cycle. core_clk_en=tick during RESET (sync-reset cores see edges).
//    PULSE: remaining<=N on accept; each tick asserts core_clk_en and decrements; after the tick that
//    brings remaining to 0 -> IDLE, done pulse next cycle. N=0: no enables, done pulse next cycle, IDLE.
//    RUN: core_clk_en=tick until STOP.
//    STOP: PULSE/RUN -> IDLE next edge, no done; STOP in IDLE is a no-op.
//  - Re-command: PULSE in RUN/PULSE restarts with new N; RUN in PULSE -> RUN (no done);
//    RESET_CORE in any state -> RESET, rst_cnt cleared.
//  - cmd_ready = ~|(state==RESET) over all channels; commands never reach a channel in RESET.
//  - Outputs decoded from flops only; no cmd_* -> output combinational path. Accept to first effect: 1 clk.
//  - Unselected channels unaffected; mask 0 accepted as NOP.
// CONFIGURATION
//  CORE_EXEC_CYCLE_COUNT_EN defined: adds output cycle_count[NUM_CORES*32-1:0]; per channel 32-bit
//  count of asserted core_clk_en, wraps at 2^32, cleared by reset and by RESET_CORE on that channel.
//  Undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  core_exec_pkg: opcode localparams/enum, channel state enum, CORE_EXEC_CNT_W=32.
//  Sub-module core_exec_channel: one FSM + remaining/rst counters (+cycle counter), generated NUM_CORES
//  times; top holds divider, cmd_ready, and command fan-out.
// TESTING
//  1 Release reset, NUM_CORES=2 -> core_reset=11 for 20 clk, done=11 pulse, cmd_ready rises, busy=00.
//  2 PULSE N=5 ch0, div=0 -> core_clk_en[0] high 5 consecutive clk, done[0] 1 clk later, ch1 silent.
//  3 SET_DIV 3 then RUN ch1 -> core_clk_en[1] every 4th clk; STOP -> low next cycle, no done.
//  4 PULSE N=0 -> zero enables, done next cycle; PULSE N=10 then PULSE N=2 mid-way -> 2 more enables.
//  5 Assert reset during PULSE -> core_reset=1, core_clk_en=0 immediately (async), sequence restarts.
//  6 CORE_EXEC_CYCLE_COUNT_EN: PULSE 7 + RUN 3 ticks -> cycle_count ch0 = 10; RESET_CORE -> 0.

Source files
------------

// File: rtl/core_exec_pkg.sv
// core_exec_pkg: shared opcodes, channel state encoding and counter width
// for the core execution controller.
package core_exec_pkg;

    localparam int CORE_EXEC_CNT_W = 32;

    // Command opcodes; 6 and 7 are treated as NOP.
    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_RESET_CORE = 3'd1,
        OP_PULSE      = 3'd2,
        OP_RUN        = 3'd3,
        OP_STOP       = 3'd4,
        OP_SET_DIV    = 3'd5
    } cmd_op_e;

    // Per-core channel states.
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RESET = 2'd1,
        CH_PULSE = 2'd2,
        CH_RUN   = 2'd3
    } ch_state_e;

endpackage

// File: rtl/core_exec_channel.sv
// core_exec_channel: one core channel. Holds the IDLE/RESET/PULSE/RUN state,
// the reset-length counter and the remaining-pulse counter.
// With CORE_EXEC_CYCLE_COUNT_EN defined it also counts asserted clock enables.
module core_exec_channel
    import core_exec_pkg::*;
#(
    parameter int PULSE_CONTROL_BITS = 12,
    parameter int RESET_CLK_CYCLES   = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          cmd_fire,
    input  logic [2:0]                    cmd_op,
    input  logic [PULSE_CONTROL_BITS-1:0] pulse_n,
    output logic                          core_clk_en,
    output logic                          core_reset,
    output logic                          busy,
`ifdef CORE_EXEC_CYCLE_COUNT_EN
    output logic [CORE_EXEC_CNT_W-1:0]    cycle_count,
`endif
    output logic                          done
);

    localparam int RST_W = (RESET_CLK_CYCLES > 1) ? $clog2(RESET_CLK_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CLK_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
    localparam logic [PULSE_CONTROL_BITS-1:0] PULSE_ONE = PULSE_CONTROL_BITS'(1);

    ch_state_e                     state_q, state_d;
    logic [RST_W-1:0]              rst_cnt_q, rst_cnt_d;
    logic [PULSE_CONTROL_BITS-1:0] remaining_q, remaining_d;
    logic                          done_q, done_d;

    // Next state: natural progress first, then an accepted command overrides it.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        case (state_q)
            CH_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = CH_IDLE;
                    rst_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_ONE;
                end
            end
            CH_PULSE: begin
                if (tick) begin
                    remaining_d = remaining_q - PULSE_ONE;
                    if (remaining_q == PULSE_ONE) begin
                        state_d = CH_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (cmd_fire) begin
            case (cmd_op)
                OP_RESET_CORE: begin
                    state_d     = CH_RESET;
                    rst_cnt_d   = '0;
                    remaining_d = '0;
                    done_d      = 1'b0;
                end
                OP_PULSE: begin
                    if (pulse_n == '0) begin
                        state_d = CH_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = CH_PULSE;
                        remaining_d = pulse_n;
                        done_d      = 1'b0;
                    end
                end
                OP_RUN: begin
                    state_d = CH_RUN;
                    done_d  = 1'b0;
                end
                OP_STOP: begin
                    if (state_q == CH_PULSE || state_q == CH_RUN) begin
                        state_d = CH_IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Channel state register; reset puts the channel into its reset sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CH_RESET;
            rst_cnt_q   <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    // PULSE never holds a zero count, so every non-idle state passes ticks through.
    assign core_clk_en = tick && (state_q != CH_IDLE);
    assign core_reset  = (state_q == CH_RESET);
    assign busy        = (state_q != CH_IDLE);
    assign done        = done_q;

`ifdef CORE_EXEC_CYCLE_COUNT_EN
    logic [CORE_EXEC_CNT_W-1:0] count_q, count_d;

    // Enable counter; RESET_CORE on this channel clears it.
    always_comb begin
        count_d = count_q + CORE_EXEC_CNT_W'(core_clk_en);
        if (cmd_fire && cmd_op == OP_RESET_CORE) begin
            count_d = '0;
        end
    end

    // Enable counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cycle_count = count_q;
`endif

endmodule

// File: rtl/core_exec_ctrl.sv
// core_exec_ctrl: per-core clock enable / reset controller. Holds the shared
// tick divider, the command handshake and fan-out to NUM_CORES channels.
// Optional feature macro: CORE_EXEC_CYCLE_COUNT_EN adds cycle_count output.
module core_exec_ctrl
    import core_exec_pkg::*;
#(
    parameter int NUM_CORES          = 1,
    parameter int PULSE_CONTROL_BITS = 12,
    parameter int DIV_BITS           = 16,
    parameter int RESET_CLK_CYCLES   = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd_op,
    input  logic [NUM_CORES-1:0]           cmd_core_sel,
    input  logic [31:0]                    cmd_arg,
    output logic [NUM_CORES-1:0]           core_clk_en,
    output logic [NUM_CORES-1:0]           core_reset,
    output logic [NUM_CORES-1:0]           busy,
`ifdef CORE_EXEC_CYCLE_COUNT_EN
    output logic [NUM_CORES*32-1:0]        cycle_count,
`endif
    output logic [NUM_CORES-1:0]           done
);

    localparam logic [DIV_BITS-1:0] DIV_ONE = DIV_BITS'(1);

    logic [DIV_BITS-1:0] div_value_q, div_value_d;
    logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
    logic                live_q, live_d;
    logic                tick_raw;
    logic                tick;
    logic                cmd_accept;
    logic [NUM_CORES-1:0] chan_reset;
    logic                unused_arg;

    assign unused_arg = ^cmd_arg;

    // The raw compare keeps the divider wrapping; the enable is held off until
    // the first edge after reset release so core_clk_en stays low in reset.
    assign tick_raw   = (div_cnt_q == div_value_q);
    assign tick       = tick_raw && live_q;
    assign cmd_ready  = ~|chan_reset;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign core_reset = chan_reset;

    // Divider next state; SET_DIV reloads the value and restarts the count.
    always_comb begin
        div_value_d = div_value_q;
        div_cnt_d   = tick_raw ? '0 : (div_cnt_q + DIV_ONE);
        live_d      = 1'b1;
        if (cmd_accept && cmd_op == OP_SET_DIV) begin
            div_value_d = cmd_arg[DIV_BITS-1:0];
            div_cnt_d   = '0;
        end
    end

    // Divider and reset-release registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_value_q <= '0;
            div_cnt_q   <= '0;
            live_q      <= 1'b0;
        end else begin
            div_value_q <= div_value_d;
            div_cnt_q   <= div_cnt_d;
            live_q      <= live_d;
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_chan
        core_exec_channel #(
            .PULSE_CONTROL_BITS (PULSE_CONTROL_BITS),
            .RESET_CLK_CYCLES   (RESET_CLK_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .cmd_fire    (cmd_accept && cmd_core_sel[i]),
            .cmd_op      (cmd_op),
            .pulse_n     (cmd_arg[PULSE_CONTROL_BITS-1:0]),
            .core_clk_en (core_clk_en[i]),
            .core_reset  (chan_reset[i]),
            .busy        (busy[i]),
`ifdef CORE_EXEC_CYCLE_COUNT_EN
            .cycle_count (cycle_count[i*32 +: 32]),
`endif
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_core_exec_ctrl.sv
// tb_core_exec_ctrl: directed and randomized bench for core_exec_ctrl with a
// cycle-level behavioural model. Honors CORE_EXEC_CYCLE_COUNT_EN.
module tb_core_exec_ctrl;

    localparam int NC  = 2;
    localparam int PCB = 12;
    localparam int DB  = 16;
    localparam int RCC = 20;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_RSTC   = 3'd1;
    localparam logic [2:0] OP_PULSE  = 3'd2;
    localparam logic [2:0] OP_RUN    = 3'd3;
    localparam logic [2:0] OP_STOP   = 3'd4;
    localparam logic [2:0] OP_SETDIV = 3'd5;

    localparam int M_IDLE  = 0;
    localparam int M_RESET = 1;
    localparam int M_PULSE = 2;
    localparam int M_RUN   = 3;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [NC-1:0] cmd_core_sel;
    logic [31:0]   cmd_arg;
    logic [NC-1:0] core_clk_en;
    logic [NC-1:0] core_reset;
    logic [NC-1:0] busy;
    logic [NC-1:0] done;
`ifdef CORE_EXEC_CYCLE_COUNT_EN
    logic [NC*32-1:0] cycle_count;
`endif

    core_exec_ctrl #(
        .NUM_CORES          (NC),
        .PULSE_CONTROL_BITS (PCB),
        .DIV_BITS           (DB),
        .RESET_CLK_CYCLES   (RCC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_core_sel (cmd_core_sel),
        .cmd_arg      (cmd_arg),
        .core_clk_en  (core_clk_en),
        .core_reset   (core_reset),
        .busy         (busy),
`ifdef CORE_EXEC_CYCLE_COUNT_EN
        .cycle_count  (cycle_count),
`endif
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what each channel is doing and for how long.
    int          mMode[NC];
    int          mElapsed[NC];
    int          mLeft[NC];
    bit          mDone[NC];
    logic [31:0] mCnt[NC];
    int          mDivv;
    int          mPhase;
    bit          mLive;

    function automatic bit mTick();
        return mLive && (mPhase == mDivv);
    endfunction

    function automatic bit mReady();
        for (int c = 0; c < NC; c++) if (mMode[c] == M_RESET) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NC; c++) begin
            mMode[c] = M_RESET; mElapsed[c] = 0; mLeft[c] = 0;
            mDone[c] = 1'b0; mCnt[c] = 32'd0;
        end
        mDivv = 0; mPhase = 0; mLive = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit t;
        bit acc;
        int orig;
        int n;
        if (!reset) begin
            modelReset();
            return;
        end
        t   = mTick();
        acc = cmd_valid && mReady();
        for (int c = 0; c < NC; c++) begin
            orig = mMode[c];
            if (t && orig != M_IDLE) mCnt[c] = mCnt[c] + 32'd1;
            mDone[c] = 1'b0;
            if (orig == M_RESET) begin
                mElapsed[c]++;
                if (mElapsed[c] == RCC) begin mMode[c] = M_IDLE; mDone[c] = 1'b1; end
            end else if (orig == M_PULSE && t) begin
                mLeft[c]--;
                if (mLeft[c] == 0) begin mMode[c] = M_IDLE; mDone[c] = 1'b1; end
            end
            if (acc && cmd_core_sel[c]) begin
                case (cmd_op)
                    OP_RSTC: begin
                        mMode[c] = M_RESET; mElapsed[c] = 0; mDone[c] = 1'b0; mCnt[c] = 32'd0;
                    end
                    OP_PULSE: begin
                        n = int'(cmd_arg[PCB-1:0]);
                        if (n == 0) begin mMode[c] = M_IDLE; mDone[c] = 1'b1; end
                        else begin mMode[c] = M_PULSE; mLeft[c] = n; mDone[c] = 1'b0; end
                    end
                    OP_RUN: begin mMode[c] = M_RUN; mDone[c] = 1'b0; end
                    OP_STOP: if (orig != M_IDLE) begin mMode[c] = M_IDLE; mDone[c] = 1'b0; end
                    default: begin end
                endcase
            end
        end
        if (acc && cmd_op == OP_SETDIV) begin
            mDivv = int'(cmd_arg[DB-1:0]); mPhase = 0;
        end else if (mPhase == mDivv) begin
            mPhase = 0;
        end else begin
            mPhase++;
        end
        mLive = 1'b1;
    endtask

    task automatic checkOne(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        logic [NC-1:0] eEn, eRst, eBusy, eDone;
        logic [63:0]   eCnt;
        eCnt = '0;
        for (int c = 0; c < NC; c++) begin
            eEn[c]   = mTick() && (mMode[c] != M_IDLE);
            eRst[c]  = (mMode[c] == M_RESET);
            eBusy[c] = (mMode[c] != M_IDLE);
            eDone[c] = mDone[c];
            eCnt[c*32 +: 32] = mCnt[c];
        end
        checkOne("core_clk_en", 64'(core_clk_en), 64'(eEn));
        checkOne("core_reset",  64'(core_reset),  64'(eRst));
        checkOne("busy",        64'(busy),        64'(eBusy));
        checkOne("done",        64'(done),        64'(eDone));
        checkOne("cmd_ready",   64'(cmd_ready),   64'(mReady()));
`ifdef CORE_EXEC_CYCLE_COUNT_EN
        checkOne("cycle_count", 64'(cycle_count), eCnt);
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [NC-1:0] sel,
                                 input logic [31:0] arg);
        cmd_valid = v; cmd_op = op; cmd_core_sel = sel; cmd_arg = arg;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic issue(input logic [2:0] op, input logic [NC-1:0] sel, input logic [31:0] arg);
        applyStimulus(1'b1, op, sel, arg);
        stepCycle();
        applyStimulus(1'b0, OP_NOP, '0, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt0, cnt1, doneAt, seen, doneCnt, readyAt, r;
        bit reissued;
        logic [2:0]  op;
        logic [31:0] arg;

        applyStimulus(1'b0, OP_NOP, '0, 32'd0);
        reset = 1'b1;
        #2 reset = 1'b0;
        modelReset();

        // Test 1: power-on reset sequence
        $display("[TB] test 1: power-on reset");
        @(negedge clk);
        checkOutput();
        checkOne("por_core_reset", 64'(core_reset), 64'(2'b11));
        checkOne("por_clk_en", 64'(core_clk_en), 64'(2'b00));
        checkOne("por_ready", 64'(cmd_ready), 64'd0);
        repeat (2) stepCycle();
        reset = 1'b1;
        checkOutput();
        cnt0 = (core_reset == 2'b11) ? 1 : 0;
        doneAt = -1;
        for (int i = 1; i <= 25; i++) begin
            stepCycle();
            if (core_reset == 2'b11) cnt0++;
            if (done == 2'b11 && doneAt < 0) doneAt = i;
        end
        checkOne("por_reset_len", 64'(cnt0), 64'(RCC));
        checkOne("por_done_at", 64'(doneAt), 64'(RCC));
        checkOne("por_ready_after", 64'(cmd_ready), 64'd1);
        checkOne("por_busy_after", 64'(busy), 64'(2'b00));

        // Test 2: PULSE 5 on channel 0 at full rate
        $display("[TB] test 2: pulse 5");
        applyStimulus(1'b1, OP_PULSE, 2'b01, 32'd5);
        cnt0 = 0; cnt1 = 0; doneAt = -1;
        for (int i = 1; i <= 10; i++) begin
            stepCycle();
            applyStimulus(1'b0, OP_NOP, '0, 32'd0);
            if (core_clk_en[0]) begin
                cnt0++;
                if (i > 5) checkOne("pulse5_consecutive", 64'(i), 64'd5);
            end
            if (core_clk_en[1]) cnt1++;
            if (done[0] && doneAt < 0) doneAt = i;
        end
        checkOne("pulse5_enables", 64'(cnt0), 64'd5);
        checkOne("pulse5_ch1_silent", 64'(cnt1), 64'd0);
        checkOne("pulse5_done_at", 64'(doneAt), 64'd6);

        // Test 3: divide by 4, RUN then STOP on channel 1
        $display("[TB] test 3: divider and run/stop");
        issue(OP_SETDIV, 2'b00, 32'd3);
        issue(OP_RUN, 2'b10, 32'd0);
        cnt1 = core_clk_en[1] ? 1 : 0;
        for (int i = 1; i < 16; i++) begin
            stepCycle();
            if (core_clk_en[1]) cnt1++;
        end
        checkOne("run_div4_enables", 64'(cnt1), 64'd4);
        issue(OP_STOP, 2'b10, 32'd0);
        checkOne("stop_clk_en", 64'(core_clk_en[1]), 64'd0);
        checkOne("stop_busy", 64'(busy[1]), 64'd0);
        checkOne("stop_no_done", 64'(done[1]), 64'd0);
        issue(OP_SETDIV, 2'b00, 32'hFFFF_0000);

        // Test 4: PULSE 0, then PULSE 10 restarted with PULSE 2
        $display("[TB] test 4: pulse 0 and restart");
        issue(OP_PULSE, 2'b01, 32'd0);
        checkOne("pulse0_done", 64'(done[0]), 64'd1);
        checkOne("pulse0_clk_en", 64'(core_clk_en[0]), 64'd0);
        checkOne("pulse0_busy", 64'(busy[0]), 64'd0);
        applyStimulus(1'b1, OP_PULSE, 2'b01, 32'd10);
        seen = 0; doneCnt = 0; reissued = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            stepCycle();
            applyStimulus(1'b0, OP_NOP, '0, 32'd0);
            if (core_clk_en[0]) seen++;
            if (done[0]) doneCnt++;
            if (seen == 4 && !reissued) begin
                applyStimulus(1'b1, OP_PULSE, 2'b01, 32'hABC0_0002);
                reissued = 1'b1;
            end
        end
        checkOne("restart_enables", 64'(seen), 64'd6);
        checkOne("restart_done_cnt", 64'(doneCnt), 64'd1);

        // Test 5: asynchronous reset in the middle of a pulse
        $display("[TB] test 5: async reset during pulse");
        applyStimulus(1'b1, OP_PULSE, 2'b10, 32'd8);
        stepCycle();
        applyStimulus(1'b0, OP_NOP, '0, 32'd0);
        repeat (2) stepCycle();
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput();
        checkOne("async_core_reset", 64'(core_reset), 64'(2'b11));
        checkOne("async_clk_en", 64'(core_clk_en), 64'(2'b00));
        checkOne("async_busy", 64'(busy), 64'(2'b11));
        repeat (2) stepCycle();
        reset = 1'b1;
        readyAt = -1;
        for (int i = 1; i <= 40 && readyAt < 0; i++) begin
            stepCycle();
            if (cmd_ready) readyAt = i;
        end
        checkOne("async_ready_at", 64'(readyAt), 64'(RCC));

`ifdef CORE_EXEC_CYCLE_COUNT_EN
        // Test 6: enable counter
        $display("[TB] test 6: cycle counter");
        applyStimulus(1'b1, OP_PULSE, 2'b01, 32'd7);
        for (int i = 1; i <= 12; i++) begin
            stepCycle();
            applyStimulus(1'b0, OP_NOP, '0, 32'd0);
            if (done[0]) break;
        end
        applyStimulus(1'b1, OP_RUN, 2'b01, 32'd0);
        seen = 0;
        for (int i = 0; i < 10 && seen < 3; i++) begin
            stepCycle();
            applyStimulus(1'b0, OP_NOP, '0, 32'd0);
            if (core_clk_en[0]) seen++;
        end
        issue(OP_STOP, 2'b01, 32'd0);
        checkOne("count_after_run", 64'(cycle_count[31:0]), 64'd10);
        issue(OP_RSTC, 2'b01, 32'd0);
        checkOne("count_cleared", 64'(cycle_count[31:0]), 64'd0);
        for (int i = 0; i < 30 && !cmd_ready; i++) stepCycle();
`endif

        // Randomized traffic against the model
        $display("[TB] random phase");
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)       op = OP_RSTC;
            else if (r < 35) op = OP_PULSE;
            else if (r < 55) op = OP_RUN;
            else if (r < 75) op = OP_STOP;
            else if (r < 85) op = OP_SETDIV;
            else             op = (r < 92) ? OP_NOP : 3'(6 + (r & 1));
            if (op == OP_PULSE)
                arg = ($urandom_range(0, 9) == 0) ? (($urandom & 32'hFFFF_F000) | 32'd3)
                                                  : 32'($urandom_range(0, 12));
            else if (op == OP_SETDIV)
                arg = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
            else
                arg = $urandom;
            applyStimulus(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, op, NC'($urandom_range(0, 3)), arg);
            if (n == 750) begin
                reset = 1'b0;
                modelReset();
                #1;
                checkOutput();
                repeat (2) stepCycle();
                reset = 1'b1;
            end
            stepCycle();
        end
        applyStimulus(1'b0, OP_NOP, '0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
